// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 receive controller.
//   ps2_state_e  : frame state machine encoding
//   ps2_entry_t  : decoded code as stored in the FIFO {ext, brk, code}
//   PS2_PREFIX_* : scan-code prefix bytes that are folded into flags
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // Prefix bytes only modify flags; they are never delivered downstream.
  function automatic logic ps2_is_prefix(input logic [7:0] b);
    return (b == PS2_PREFIX_EXT) || (b == PS2_PREFIX_BRK);
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// ---------------------------------------------------------------------------
// ps2_code_fifo
// First-word-fall-through FIFO for decoded scan codes.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   push, wr_entry : write request and data
//   pop            : read request (ignored when empty)
//   rd_entry       : head entry, valid whenever !empty
//   full, empty    : status
//   drop           : push rejected this cycle (full with no pop)
// ---------------------------------------------------------------------------
module ps2_code_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ps2_entry_t wr_entry,
  input  logic       pop,
  output ps2_entry_t rd_entry,
  output logic       full,
  output logic       empty,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);

  ps2_entry_t    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push will land in.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign rd_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_entry;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_rx_ctrl
// PS/2 keyboard receive controller running on the system clock. Synchronises
// the raw pins, frames bytes on ps2_clk falling edges, checks start/parity/
// stop, abandons stalled frames, folds E0/F0 prefixes into flags and buffers
// decoded codes in a FWFT FIFO.
// Ports:
//   clk, rst_n          : system clock, async active-low reset
//   ps2_clk, ps2_data   : raw keyboard pins (asynchronous)
//   code_out            : scan code at FIFO head
//   code_ext/code_break : head code was preceded by E0 / F0
//   code_valid          : FIFO non-empty
//   code_ready          : consumer takes head when valid && ready
//   frame_err           : 1-cycle pulse, bad start/parity/stop or timeout
//   overflow            : 1-cycle pulse, decoded code dropped (FIFO full)
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for start bit (data low on a clk fall)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then back to idle
// ---------------------------------------------------------------------------
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code_out,
  output logic       code_ext,
  output logic       code_break,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int          TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   ps2_fall;
  logic                   data_s;

  ps2_state_e             state;
  ps2_state_e             state_next;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          tmo_cnt;
  logic                   tmo_hit;

  logic                   start_ok;
  logic                   shift_en;
  logic                   par_en;
  logic                   byte_ok;
  logic                   err_cond;

  logic [7:0]             byte_q;
  logic                   byte_good;
  logic                   ext_flag;
  logic                   brk_flag;

  logic                   fifo_push;
  ps2_entry_t             fifo_wr;
  ps2_entry_t             fifo_rd;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_drop;

  // Synchronisers reset high so the idle-high bus shows no edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign ps2_fall = clk_prev && !clk_sync[SYNC_STAGES-1];
  assign data_s   = data_sync[SYNC_STAGES-1];

  // A fall in the terminal cycle clears the counter, so it wins over timeout.
  assign tmo_hit = (state != ST_IDLE) && !ps2_fall && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (ps2_fall || state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (tmo_hit) begin
      state_next = ST_IDLE;
    end else if (ps2_fall) begin
      unique case (state)
        ST_IDLE:   if (!data_s) state_next = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs (datapath strobes and error condition)
  always_comb begin
    start_ok = 1'b0;
    shift_en = 1'b0;
    par_en   = 1'b0;
    byte_ok  = 1'b0;
    err_cond = tmo_hit;
    if (ps2_fall) begin
      unique case (state)
        ST_IDLE: begin
          start_ok = !data_s;
          err_cond = data_s;
        end
        ST_DATA:   shift_en = 1'b1;
        ST_PARITY: par_en   = 1'b1;
        ST_STOP: begin
          byte_ok  = data_s && ((^shreg) ^ par_bit);
          err_cond = !(data_s && ((^shreg) ^ par_bit));
        end
        default: err_cond = 1'b1;
      endcase
    end
  end

  // Frame datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      byte_q    <= '0;
      byte_good <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (start_ok) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shreg <= {data_s, shreg[7:1]};
      end
      if (par_en) begin
        par_bit <= data_s;
      end
      byte_good <= byte_ok;
      if (byte_ok) begin
        byte_q <= shreg;
      end
      frame_err <= err_cond;
    end
  end

  // Prefix folding: flags apply to the next non-prefix byte only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (err_cond) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_good) begin
      if (byte_q == PS2_PREFIX_EXT) begin
        ext_flag <= 1'b1;
      end else if (byte_q == PS2_PREFIX_BRK) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  assign fifo_push    = byte_good && !ps2_is_prefix(byte_q);
  assign fifo_wr.ext  = ext_flag;
  assign fifo_wr.brk  = brk_flag;
  assign fifo_wr.code = byte_q;

  ps2_code_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .wr_entry (fifo_wr),
    .pop      (code_ready),
    .rd_entry (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else begin
      overflow <= fifo_drop;
    end
  end

  assign code_valid = !fifo_empty;
  assign code_out   = fifo_rd.code;
  assign code_ext   = fifo_rd.ext;
  assign code_break = fifo_rd.brk;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
module tb_ps2_rx_ctrl;
  import ps2_pkg::*;

  localparam int TMO = 200;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code_out;
  logic       code_ext;
  logic       code_break;
  logic       code_valid;
  logic       code_ready;
  logic       frame_err;
  logic       overflow;

  int checks;
  int errors;
  int ferr_cnt;
  int ovf_cnt;
  int beat_cnt;
  ps2_entry_t sb[$];

  ps2_rx_ctrl #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_out   (code_out),
    .code_ext   (code_ext),
    .code_break (code_break),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation did not complete within 60000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_clk(5);
    ps2_clk = 1'b0;
    wait_clk(10);
    ps2_clk = 1'b1;
    wait_clk(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_flip);
    ps2_bit(!stop_bad);
    ps2_data = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    ps2_data = 1'b1;
  endtask

  task automatic expect_code(input logic ext, input logic brk, input logic [7:0] c);
    ps2_entry_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = c;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    wait_clk(20);
    check(name, sb.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, int'({code_out, code_ext, code_break, code_valid, frame_err, overflow}), 0);
  endtask

  initial begin
    int ferr0;
    int beat0;
    checks     = 0;
    errors     = 0;
    ferr_cnt   = 0;
    ovf_cnt    = 0;
    beat_cnt   = 0;
    rst_n      = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    code_ready = 1'b1;

    // Scoreboard monitor: pops one expectation per accepted beat.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (code_valid && code_ready) begin
            beat_cnt++;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL beat_unexpected: got code 0x%0h ext %0b brk %0b, expected no beat",
                       code_out, code_ext, code_break);
            end else begin
              ps2_entry_t e;
              e = sb.pop_front();
              check("beat_entry", int'({code_ext, code_break, code_out}), int'(e));
            end
          end
          if (frame_err) ferr_cnt++;
          if (overflow) ovf_cnt++;
        end
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clk(10);
    check_outputs_zero("post_reset_idle");

    // Plain 0x1C
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_drained("t1_drained");
    check("t1_frame_err", ferr_cnt, 0);
    check("t1_beats", beat_cnt, 1);

    // E0 F0 75 then plain 1C
    beat0 = beat_cnt;
    expect_code(1'b1, 1'b1, 8'h75);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("t2_no_prefix_beat", beat_cnt - beat0, 0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_drained("t2_drained");
    check("t2_beats", beat_cnt - beat0, 2);

    // Bad parity, bad stop, good frame
    ferr0 = ferr_cnt;
    beat0 = beat_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    wait_clk(5);
    check("t3_parity_err", ferr_cnt - ferr0, 1);
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_clk(5);
    check("t3_stop_err", ferr_cnt - ferr0, 2);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_drained("t3_drained");
    check("t3_beats", beat_cnt - beat0, 1);
    check("t3_err_total", ferr_cnt - ferr0, 2);

    // Timeout mid-frame
    ferr0 = ferr_cnt;
    send_partial(8'h55, 4);
    wait_clk(TMO + 10);
    check("t4_timeout_err", ferr_cnt - ferr0, 1);
    expect_code(1'b0, 1'b0, 8'h32);
    send_frame(8'h32, 1'b0, 1'b0);
    check_drained("t4_drained");

    // Timeout clears a pending F0 prefix
    ferr0 = ferr_cnt;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_partial(8'hAA, 4);
    wait_clk(TMO + 10);
    check("t5_timeout_err", ferr_cnt - ferr0, 1);
    expect_code(1'b0, 1'b0, 8'h32);
    send_frame(8'h32, 1'b0, 1'b0);
    check_drained("t5_drained");

    // Overflow on the fifth code while stalled
    code_ready = 1'b0;
    expect_code(1'b0, 1'b0, 8'h16);
    expect_code(1'b0, 1'b0, 8'h1E);
    expect_code(1'b0, 1'b0, 8'h26);
    expect_code(1'b0, 1'b0, 8'h25);
    send_frame(8'h16, 1'b0, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b0);
    send_frame(8'h26, 1'b0, 1'b0);
    send_frame(8'h25, 1'b0, 1'b0);
    check("t6_no_ovf_yet", ovf_cnt, 0);
    check("t6_valid_held", int'(code_valid), 1);
    check("t6_head", int'(code_out), 8'h16);
    send_frame(8'h2E, 1'b0, 1'b0);
    check("t6_ovf_once", ovf_cnt, 1);
    code_ready = 1'b1;
    check_drained("t6_drained");
    check("t6_valid_low", int'(code_valid), 0);
    check("t6_ovf_final", ovf_cnt, 1);

    // Reset mid-frame with a code still buffered
    code_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t7_buffered", int'(code_valid), 1);
    send_partial(8'h1C, 3);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("t7_in_reset");
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    code_ready = 1'b1;
    ferr0 = ferr_cnt;
    beat0 = beat_cnt;
    wait_clk(10);
    check("t7_no_err_after_reset", ferr_cnt - ferr0, 0);
    expect_code(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_drained("t7_drained");
    check("t7_beats", beat_cnt - beat0, 1);
    check("t7_no_err", ferr_cnt - ferr0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
System-clock controller that sequences PS/2 keyboard reception. It synchronises the raw ps2_clk/ps2_data pins and runs the frame state machine, including start, parity and stop checking and timeout resync. It folds E0/F0 prefix bytes into flags on the following scan code and buffers decoded codes in a small FIFO behind a valid/ready handshake. It sits between the keyboard pins and the downstream keymap/CPU-interface logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on ps2_clk and ps2_data (minimum 2)
TIMEOUT_CYCLES, 20000, clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned (400 us at 50 MHz)
FIFO_DEPTH, 4, decoded-code entries buffered (power of 2, minimum 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; asynchronous, active-low
ps2_clk  in  1  raw keyboard clock pin, asynchronous
ps2_data  in  1  raw keyboard data pin, asynchronous
code_out  out  8  scan code at FIFO head
code_ext  out  1  head code was preceded by E0
code_break  out  1  head code was preceded by F0 (key release)
code_valid  out  1  FIFO non-empty
code_ready  in  1  consumer accepts head when code_valid && code_ready
frame_err  out  1  1-cycle pulse: bad start, parity, stop, or timeout
overflow  out  1  1-cycle pulse: decoded code dropped because FIFO full

Behaviour:
- Reset: all outputs 0, FSM IDLE, prefix flags 0, FIFO empty, timeout counter 0. Sync registers reset to 1 (idle-high bus), so no false edge follows reset. Reset mid-frame discards partial frame silently.
- Edge detect: fall = synced_prev && !synced_now on ps2_clk. ps2_data is sampled from its synced copy in the same cycle. All FSM actions occur only on fall cycles, except timeout.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA with bit_cnt=0. On fall with data=1, stay in IDLE and pulse frame_err.
  - DATA: shift LSB-first (shreg <= {d, shreg[7:1]}); bit_cnt 0..7; after 8th bit go to PARITY.
  - PARITY: store p, go to STOP.
  - STOP: go to IDLE. Byte is good iff stop=1 and (^shreg ^ p)=1 (odd parity). Otherwise pulse frame_err and discard the byte.
- Timeout: counter clears on every fall and while in IDLE. In any other state, when it reaches TIMEOUT_CYCLES-1, go to IDLE next cycle, pulse frame_err, discard, clear prefix flags. A fall in that same cycle wins (counter clears, no timeout).
- Prefix decode, on good byte:
  - 8'hE0 sets ext.
  - 8'hF0 sets brk.
  - Any other byte pushes {ext, brk, byte} and clears both flags.
  - Prefixes never push. Any frame_err clears both flags.
- Latency: good byte registered 1 cycle after stop-bit fall cycle; FIFO write next edge; code_valid high 2 cycles after the fall cycle (pin to valid = SYNC_STAGES+3 clk, within ±1 for pin asynchrony).
- FIFO: first-word-fall-through; code_* reflect head combinationally from storage; pop on code_valid && code_ready.
  - Push while full with no pop: drop the new entry, pulse overflow, keep contents.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: not possible, because a written entry becomes valid next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Outputs frame_err and overflow are registered.

Decomposition:
- Package ps2_pkg: FSM state enum; constants PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0; packed entry type {ext, brk, code[7:0]} (10 bits).
- Sub-module ps2_code_fifo: parameterised FWFT FIFO with push/pop/full/empty.
- Sync, edge detect, FSM, timeout and prefix decode stay in ps2_rx_ctrl.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), ready=1 -> one beat code_out=0x1C, ext=0, brk=0; frame_err never pulses.
- Frames E0, F0, 75 -> exactly one beat code_out=0x75, ext=1, brk=1; no beats for the prefixes; flags 0 on the next plain 0x1C.
- 0x1C with parity 1, then 0x1C with stop 0, then a good 0x1C -> two frame_err pulses and a single beat 0x1C.
- 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+10 -> one frame_err; following good frame 0x32 delivered correctly. Repeat with F0 sent before the stall -> prefix cleared, 0x32 has brk=0.
- code_ready=0, send 0x16, 0x1E, 0x26, 0x25, 0x2E -> overflow pulses once on the 5th; ready=1 drains 16, 1E, 26, 25 in order; then code_valid=0.
- Assert rst_n low mid-DATA for 3 cycles, release, send good 0x1C -> all outputs 0 during reset, no frame_err after release, single beat 0x1C.
